// File: rtl/ddr_frame_sched.sv
// Triple-buffered frame scheduler: hands DMA write/read descriptors to four frame
// sections so the reader always sees the newest complete frame without tearing.
module ddr_frame_sched #(
  parameter int MAX_ADDR   = 518400,
  parameter int LEN_WIDTH  = $clog2(MAX_ADDR),
  parameter int BANK_WIDTH = 3,
  parameter int SEC_WIDTH  = 2
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic                                    wr_start,
  input  logic                                    rd_start,
  input  logic                                    wr_cfg_ready,
  input  logic                                    rd_cfg_ready,
  input  logic                                    wr_done,
  input  logic                                    rd_done,
  output logic [BANK_WIDTH+SEC_WIDTH+LEN_WIDTH-1:0] wr_desc_addr,
  output logic [BANK_WIDTH+SEC_WIDTH+LEN_WIDTH-1:0] rd_desc_addr,
  output logic [LEN_WIDTH-1:0]                    wr_desc_len,
  output logic [LEN_WIDTH-1:0]                    rd_desc_len,
  output logic                                    wr_cfg_valid,
  output logic                                    rd_cfg_valid,
  output logic                                    wr_busy,
  output logic                                    rd_busy,
  output logic                                    frame_avail,
  output logic                                    rd_skip,
  output logic                                    wr_reject,
  output logic                                    rd_reject,
  output logic [15:0]                             frame_cnt
);

  localparam int NUM_SEC = 2 ** SEC_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} chan_state_t;

  chan_state_t          wr_state, wr_state_n, rd_state, rd_state_n;
  logic [SEC_WIDTH-1:0] wr_sec, wr_sec_n, rd_sec, rd_sec_n;
  logic [SEC_WIDTH-1:0] latest_sec, latest_sec_n, free_sec;
  logic                 latest_vld, latest_vld_n;
  logic [15:0]          frame_cnt_n;
  logic                 rd_skip_n, wr_reject_n, rd_reject_n;
  logic [NUM_SEC-1:0]   used;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state   <= IDLE;
      rd_state   <= IDLE;
      wr_sec     <= '0;
      rd_sec     <= '0;
      latest_sec <= '0;
      latest_vld <= 1'b0;
      frame_cnt  <= '0;
      rd_skip    <= 1'b0;
      wr_reject  <= 1'b0;
      rd_reject  <= 1'b0;
    end else begin
      wr_state   <= wr_state_n;
      rd_state   <= rd_state_n;
      wr_sec     <= wr_sec_n;
      rd_sec     <= rd_sec_n;
      latest_sec <= latest_sec_n;
      latest_vld <= latest_vld_n;
      frame_cnt  <= frame_cnt_n;
      rd_skip    <= rd_skip_n;
      wr_reject  <= wr_reject_n;
      rd_reject  <= rd_reject_n;
    end
  end

  // Ordering matters: write commit, then reader decision, then writer section pick.
  always_comb begin
    wr_state_n   = wr_state;
    rd_state_n   = rd_state;
    wr_sec_n     = wr_sec;
    rd_sec_n     = rd_sec;
    latest_sec_n = latest_sec;
    latest_vld_n = latest_vld;
    frame_cnt_n  = frame_cnt;
    rd_skip_n    = 1'b0;
    wr_reject_n  = 1'b0;
    rd_reject_n  = 1'b0;
    used         = '0;
    free_sec     = '0;

    case (wr_state)
      ISSUE: if (wr_cfg_ready) wr_state_n = BUSY;
      BUSY: begin
        if (wr_done) begin
          wr_state_n   = IDLE;
          latest_sec_n = wr_sec;
          latest_vld_n = 1'b1;
          frame_cnt_n  = frame_cnt + 16'd1;
        end
      end
      default: ;
    endcase
    if (wr_state != IDLE && wr_start) wr_reject_n = 1'b1;

    case (rd_state)
      IDLE: begin
        if (rd_start) begin
          if (latest_vld_n) begin
            rd_state_n = ISSUE;
            rd_sec_n   = latest_sec_n;
          end else begin
            rd_skip_n = 1'b1;
          end
        end
      end
      ISSUE: if (rd_cfg_ready) rd_state_n = BUSY;
      BUSY:  if (rd_done) rd_state_n = IDLE;
      default: ;
    endcase
    if (rd_state != IDLE && rd_start) rd_reject_n = 1'b1;

    // At most two sections are pinned (reader and latest), so one of four is always free.
    if (rd_state_n != IDLE) used[rd_sec_n] = 1'b1;
    if (latest_vld_n) used[latest_sec_n] = 1'b1;
    for (int i = NUM_SEC - 1; i >= 0; i--) begin
      if (!used[i]) free_sec = SEC_WIDTH'(i);
    end

    if (wr_state == IDLE && wr_start) begin
      wr_state_n = ISSUE;
      wr_sec_n   = free_sec;
    end
  end

  assign wr_desc_addr = {{BANK_WIDTH{1'b0}}, wr_sec, {LEN_WIDTH{1'b0}}};
  assign rd_desc_addr = {{BANK_WIDTH{1'b0}}, rd_sec, {LEN_WIDTH{1'b0}}};
  assign wr_desc_len  = LEN_WIDTH'(MAX_ADDR);
  assign rd_desc_len  = LEN_WIDTH'(MAX_ADDR);
  assign wr_cfg_valid = (wr_state == ISSUE);
  assign rd_cfg_valid = (rd_state == ISSUE);
  assign wr_busy      = (wr_state != IDLE);
  assign rd_busy      = (rd_state != IDLE);
  assign frame_avail  = latest_vld;

endmodule

// File: tb/tb_ddr_frame_sched.sv
// Bench for ddr_frame_sched: directed scenarios plus random traffic, all checked
// every cycle against a section-allocation model built from the frame rules.
module tb_ddr_frame_sched;

  localparam int LEN_W  = 19;
  localparam int ADDR_W = 3 + 2 + LEN_W;

  logic              aclk = 1'b0;
  logic              areset, wr_start, rd_start, wr_cfg_ready, rd_cfg_ready, wr_done, rd_done;
  logic [ADDR_W-1:0] wr_desc_addr, rd_desc_addr;
  logic [LEN_W-1:0]  wr_desc_len, rd_desc_len;
  logic              wr_cfg_valid, rd_cfg_valid, wr_busy, rd_busy, frame_avail;
  logic              rd_skip, wr_reject, rd_reject;
  logic [15:0]       frame_cnt;

  ddr_frame_sched dut (
    .aclk(aclk), .areset(areset),
    .wr_start(wr_start), .rd_start(rd_start),
    .wr_cfg_ready(wr_cfg_ready), .rd_cfg_ready(rd_cfg_ready),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_desc_addr(wr_desc_addr), .rd_desc_addr(rd_desc_addr),
    .wr_desc_len(wr_desc_len), .rd_desc_len(rd_desc_len),
    .wr_cfg_valid(wr_cfg_valid), .rd_cfg_valid(rd_cfg_valid),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .frame_avail(frame_avail),
    .rd_skip(rd_skip), .wr_reject(wr_reject), .rd_reject(rd_reject),
    .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Model: channel phase 0 = no job, 1 = descriptor offered, 2 = transfer running.
  int m_wr_phase, m_rd_phase, m_wr_sec, m_rd_sec, m_latest, m_cnt;
  bit m_vld, m_skip, m_wr_rej, m_rd_rej;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sec_addr(input int sec);
    return 32'(sec) << LEN_W;
  endfunction

  task automatic model_step();
    int  wp, rp;
    bit  taken [4];
    int  pick;
    wp = m_wr_phase;
    rp = m_rd_phase;
    m_skip = 0; m_wr_rej = 0; m_rd_rej = 0;
    if (areset) begin
      m_wr_phase = 0; m_rd_phase = 0; m_wr_sec = 0; m_rd_sec = 0;
      m_latest = 0; m_vld = 0; m_cnt = 0;
      return;
    end
    if (wp == 2 && wr_done) begin
      m_latest = m_wr_sec; m_vld = 1; m_cnt = (m_cnt + 1) % 65536; m_wr_phase = 0;
    end else if (wp == 1 && wr_cfg_ready) begin
      m_wr_phase = 2;
    end
    if (wp != 0 && wr_start) m_wr_rej = 1;
    if (rp == 0 && rd_start) begin
      if (m_vld) begin m_rd_sec = m_latest; m_rd_phase = 1; end
      else m_skip = 1;
    end else if (rp == 1 && rd_cfg_ready) m_rd_phase = 2;
    else if (rp == 2 && rd_done) m_rd_phase = 0;
    if (rp != 0 && rd_start) m_rd_rej = 1;
    if (wp == 0 && wr_start) begin
      foreach (taken[s]) taken[s] = (m_rd_phase != 0 && m_rd_sec == s) || (m_vld && m_latest == s);
      pick = -1;
      for (int s = 3; s >= 0; s--) if (!taken[s]) pick = s;
      if (pick < 0) begin
        n_checks++; n_fail++;
        $display("[TB] FAIL model_free_section actual=none required=some");
        pick = 0;
      end
      m_wr_sec = pick; m_wr_phase = 1;
    end
  endtask

  always @(negedge aclk) begin
    if (check_en) begin
      check_output("wr_cfg_valid", 32'(wr_cfg_valid), 32'(m_wr_phase == 1));
      check_output("rd_cfg_valid", 32'(rd_cfg_valid), 32'(m_rd_phase == 1));
      check_output("wr_busy", 32'(wr_busy), 32'(m_wr_phase != 0));
      check_output("rd_busy", 32'(rd_busy), 32'(m_rd_phase != 0));
      check_output("wr_desc_addr", 32'(wr_desc_addr), sec_addr(m_wr_sec));
      check_output("rd_desc_addr", 32'(rd_desc_addr), sec_addr(m_rd_sec));
      check_output("wr_desc_len", 32'(wr_desc_len), 32'd518400);
      check_output("rd_desc_len", 32'(rd_desc_len), 32'd518400);
      check_output("frame_avail", 32'(frame_avail), 32'(m_vld));
      check_output("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      check_output("rd_skip", 32'(rd_skip), 32'(m_skip));
      check_output("wr_reject", 32'(wr_reject), 32'(m_wr_rej));
      check_output("rd_reject", 32'(rd_reject), 32'(m_rd_rej));
    end
  end

  // Drives one clock of inputs; returns 2 time units after the edge.
  task automatic apply_stimulus(input bit ws, rs, wcr, rcr, wd, rdd, rst);
    wr_start = ws; rd_start = rs; wr_cfg_ready = wcr; rd_cfg_ready = rcr;
    wr_done = wd; rd_done = rdd; areset = rst;
    @(posedge aclk);
    model_step();
    #2;
  endtask

  function automatic int wr_section();
    return int'(wr_desc_addr[LEN_W +: 2]);
  endfunction

  function automatic int rd_section();
    return int'(rd_desc_addr[LEN_W +: 2]);
  endfunction

  initial begin
    {wr_start, rd_start, wr_cfg_ready, rd_cfg_ready, wr_done, rd_done} = '0;
    areset = 1'b1;
    m_wr_phase = 0; m_rd_phase = 0; m_wr_sec = 0; m_rd_sec = 0;
    m_latest = 0; m_vld = 0; m_cnt = 0; m_skip = 0; m_wr_rej = 0; m_rd_rej = 0;
    apply_stimulus(0,0,0,0,0,0,1);
    apply_stimulus(0,0,0,0,0,0,1);
    check_en = 1'b1;
    check_output("lit_reset_busy", 32'(wr_busy | rd_busy), 32'd0);
    check_output("lit_reset_avail", 32'(frame_avail), 32'd0);
    check_output("lit_reset_cnt", 32'(frame_cnt), 32'd0);

    // Read with nothing stored is refused.
    apply_stimulus(0,1,0,0,0,0,0);
    check_output("lit_skip", 32'(rd_skip), 32'd1);
    check_output("lit_skip_novalid", 32'(rd_cfg_valid), 32'd0);
    apply_stimulus(0,0,0,0,0,0,0);
    check_output("lit_skip_clear", 32'(rd_skip), 32'd0);

    // First write, descriptor held while the DMA stalls.
    apply_stimulus(1,0,0,0,0,0,0);
    check_output("lit_wr_valid_0", 32'(wr_cfg_valid), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(0,0,0,0,0,0,0);
      check_output("lit_wr_valid_hold", 32'(wr_cfg_valid), 32'd1);
    end
    check_output("lit_wr_sec0", 32'(wr_section()), 32'd0);
    check_output("lit_wr_len", 32'(wr_desc_len), 32'd518400);
    apply_stimulus(0,0,1,0,0,0,0);
    check_output("lit_wr_valid_drop", 32'(wr_cfg_valid), 32'd0);
    apply_stimulus(0,0,0,0,1,0,0);
    check_output("lit_avail1", 32'(frame_avail), 32'd1);
    check_output("lit_cnt1", 32'(frame_cnt), 32'd1);

    // Read section 0 while a new write goes to section 1.
    apply_stimulus(0,1,0,0,0,0,0);
    check_output("lit_rd_sec0", 32'(rd_section()), 32'd0);
    apply_stimulus(1,0,0,0,0,0,0);
    check_output("lit_wr_sec1", 32'(wr_section()), 32'd1);
    apply_stimulus(0,0,1,1,0,0,0);
    apply_stimulus(0,0,0,0,1,0,0);
    check_output("lit_model_latest1", 32'(m_latest), 32'd1);
    apply_stimulus(0,0,0,0,0,1,0);

    // Read section 1, write reuses 0, a second write start is rejected.
    apply_stimulus(0,1,0,0,0,0,0);
    check_output("lit_rd_sec1", 32'(rd_section()), 32'd1);
    apply_stimulus(0,0,0,1,0,0,0);
    apply_stimulus(1,0,0,0,0,0,0);
    check_output("lit_wr_sec0_again", 32'(wr_section()), 32'd0);
    apply_stimulus(1,0,0,0,0,0,0);
    check_output("lit_wr_reject", 32'(wr_reject), 32'd1);
    check_output("lit_wr_sec_kept", 32'(wr_section()), 32'd0);
    apply_stimulus(0,0,1,0,0,0,0);
    check_output("lit_wr_reject_clear", 32'(wr_reject), 32'd0);
    apply_stimulus(0,0,0,0,0,1,0);

    // Commit and read in the same cycle: reader gets the fresh frame.
    apply_stimulus(0,1,0,0,1,0,0);
    check_output("lit_same_cycle_rd_sec", 32'(rd_section()), 32'd0);
    check_output("lit_same_cycle_valid", 32'(rd_cfg_valid), 32'd1);
    check_output("lit_cnt3", 32'(frame_cnt), 32'd3);

    // Reset in the middle of a write abandons it.
    apply_stimulus(0,0,0,1,0,0,0);
    apply_stimulus(1,0,0,0,0,0,0);
    check_output("lit_wr_sec1_b", 32'(wr_section()), 32'd1);
    apply_stimulus(0,0,1,0,0,0,0);
    apply_stimulus(0,0,0,0,0,0,1);
    apply_stimulus(0,0,0,0,1,1,0);
    check_output("lit_post_reset_cnt", 32'(frame_cnt), 32'd0);
    check_output("lit_post_reset_avail", 32'(frame_avail), 32'd0);
    check_output("lit_post_reset_busy", 32'(wr_busy), 32'd0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      apply_stimulus($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 299) == 0);
    end

    @(negedge aclk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_frame_sched.md
DDR_FRAME_SCHED -- requirements
Module: ddr_frame_sched

Interface
REQ-001 Parameter MAX_ADDR, default 518400: frame length in DMA length units, driven on both desc_len outputs.
REQ-002 Parameter LEN_WIDTH, default $clog2(MAX_ADDR): width of desc_len and of the section offset field.
REQ-003 Parameter BANK_WIDTH, default 3: bank field width, always driven zero.
REQ-004 Parameter SEC_WIDTH, fixed 2: section index width (4 sections).
REQ-005 aclk  in  1  sole clock; all logic rising-edge.
REQ-006 areset  in  1  synchronous, active-high reset.
REQ-007 wr_start  in  1  one-cycle request to store a new frame.
REQ-008 rd_start  in  1  one-cycle request to fetch a frame.
REQ-009 wr_cfg_ready / rd_cfg_ready  in  1 each  DMA descriptor accept.
REQ-010 wr_done / rd_done  in  1 each  DMA st_last pulse, transfer complete.
REQ-011 wr_desc_addr / rd_desc_addr  out  BANK_WIDTH+SEC_WIDTH+LEN_WIDTH each  {zero bank, section, zero offset}.
REQ-012 wr_desc_len / rd_desc_len  out  LEN_WIDTH each  constant MAX_ADDR.
REQ-013 wr_cfg_valid / rd_cfg_valid  out  1 each  descriptor valid.
REQ-014 wr_busy / rd_busy  out  1 each  channel not IDLE.
REQ-015 frame_avail  out  1  at least one complete frame stored.
REQ-016 rd_skip  out  1  one-cycle pulse: rd_start refused.
REQ-017 wr_reject / rd_reject  out  1 each  one-cycle pulse: start received while busy.
REQ-018 frame_cnt  out  16  completed writes, wraps at 65535->0.

Function
REQ-019 Each channel has its own FSM: IDLE -> ISSUE -> BUSY -> IDLE.
REQ-020 IDLE->ISSUE on start in the cycle after start is sampled; cfg_valid asserts that cycle (latency 1).
REQ-021 ISSUE: cfg_valid held high, desc_addr stable, until cfg_ready sampled high; then ->BUSY, cfg_valid low next cycle.
REQ-022 BUSY->IDLE on the cycle done is sampled; done outside BUSY is ignored.
REQ-023 start in ISSUE or BUSY is ignored and pulses the matching *_reject next cycle.
REQ-024 Registers: wr_sec, rd_sec, latest_sec, latest_vld.
REQ-025 Section free = not wr_sec while wr_busy, not rd_sec while rd_busy, not latest_sec while latest_vld.
REQ-026 On wr_start accept, wr_sec := lowest-index free section; a free section always exists.
REQ-027 On wr_done in BUSY: latest_sec := wr_sec, latest_vld := 1, frame_cnt increments; old latest becomes free unless being read.
REQ-028 On rd_start accept with latest_vld=1 (including latest updated same cycle): rd_sec := latest_sec; repeated reads of an unchanged latest are allowed.
REQ-029 rd_start with latest_vld=0 (after same-cycle wr_done update): channel stays IDLE, rd_skip pulses next cycle.
REQ-030 wr_done and rd_start same cycle: write commit applies first; reader gets the just-completed section.
REQ-031 Simultaneous wr_start and rd_start: both accepted; writer never selects the section chosen by the reader.
REQ-032 frame_avail = latest_vld.

Reset
REQ-033 areset sampled high, any state: both FSMs IDLE, cfg_valid 0, busy 0, wr_sec 0, rd_sec 0, latest_sec 0, latest_vld 0, frame_cnt 0, pulses 0.
REQ-034 Reset mid-transfer abandons it; done arriving after reset is ignored.

Verification
REQ-035 Reset, rd_start -> rd_skip at cycle+1, rd_cfg_valid stays 0.
REQ-036 wr_start, cfg_ready held low 3 cycles -> wr_cfg_valid high 4 cycles, wr_desc_addr section 0, wr_desc_len 518400; wr_done -> frame_avail=1, frame_cnt=1.
REQ-037 After one frame in section 0: rd_start, then wr_start during read -> reader section 0, writer section 1; wr_done -> latest_sec 1.
REQ-038 Write sections 0,1 complete; reading 1; write 0 in progress; second wr_start -> wr_reject pulse, wr_sec unchanged.
REQ-039 wr_done and rd_start same cycle -> rd_desc_addr section equals just-completed wr_sec.
REQ-040 areset pulsed during wr BUSY, then wr_done -> frame_cnt 0, frame_avail 0.
